// File: rtl/sll_seq.sv
// sll_seq -- multi-cycle logical shift-left unit, one bit position per clock.
//
// Shifts operand a left by b positions (b >= N clamps to N, giving zero) and
// presents the truncated N-bit result on c. Sequential counterpart of the
// combinational shifter in the ALU lab, using the same a/b/c operand naming.
//
// Optional build macro: SLL_SEQ_ROTATE_EN
//   undefined : logical shift-left, zero fill, shift amount clamped to N
//   defined   : rotate-left, shift amount taken as b mod N
//
// Ports:
//   clk    in   1  rising-edge clock
//   rst_n  in   1  asynchronous active-low reset; aborts any operation in flight
//   start  in   1  request, sampled only while idle
//   a      in   N  value to shift, captured when start is accepted
//   b      in   N  unsigned shift amount, captured when start is accepted
//   c      out  N  result; written on completion, held until the next completion
//   busy   out  1  high from acceptance through the done cycle
//   done   out  1  single-cycle completion pulse
//
// Handshake: a request is accepted on a rising edge where start=1 and busy=0.
// While busy=1 start is ignored (nothing is queued). done pulses for exactly
// one cycle with c already valid; busy drops in the following cycle.
module sll_seq #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] c,
    output logic         busy,
    output logic         done
);

    localparam int           CW  = $clog2(N) + 1;
    localparam logic [N-1:0] N_B = N'(N);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [N-1:0]  acc;
    logic [CW-1:0] cnt;
    logic [N-1:0]  cnt_load;   // full-width step count before narrowing to cnt
    logic [N-1:0]  acc_step;   // acc after one shift/rotate step

    always_comb begin
        cnt_load = '0;
        acc_step = '0;
`ifdef SLL_SEQ_ROTATE_EN
        cnt_load = b % N_B;
        acc_step = {acc[N-2:0], acc[N-1]};
`else
        // Shifting N or more places empties the register, so N steps suffice.
        cnt_load = (b >= N_B) ? N_B : b;
        acc_step = {acc[N-2:0], 1'b0};
`endif
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and status outputs
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                // The step after the count runs out publishes the result.
                if (cnt == '0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: operand capture, stepping, result publication
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            cnt <= '0;
            c   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc <= a;
                        cnt <= CW'(cnt_load);
                    end
                end
                SHIFT: begin
                    if (cnt != '0) begin
                        acc <= acc_step;
                        cnt <= cnt - CW'(1);
                    end else begin
                        c <= acc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sll_seq.sv
// tb_sll_seq -- self-checking bench for sll_seq (N=4).
// Inputs are driven on the falling edge, outputs sampled on the falling edge.
module tb_sll_seq;

    localparam int N    = 4;
    localparam int MASK = (1 << N) - 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] c;
    logic         busy;
    logic         done;

    int checks   = 0;
    int failures = 0;

    logic [N-1:0] exp_q[$];

    typedef struct {
        int a;
        int b;
        int exp_c;
        int exp_lat;   // edges after acceptance until done is observed
    } vec_t;

    vec_t tbl[8];

    sll_seq #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .c     (c),
        .busy  (busy),
        .done  (done)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int model_steps(input int bv);
`ifdef SLL_SEQ_ROTATE_EN
        return bv % N;
`else
        return (bv >= N) ? N : bv;
`endif
    endfunction

    function automatic int model_c(input int av, input int bv);
        int s;
        s = model_steps(bv);
`ifdef SLL_SEQ_ROTATE_EN
        return ((av * (1 << s)) + (av / (1 << (N - s)))) & MASK;
`else
        return (av * (1 << s)) & MASK;
`endif
    endfunction

    // ---------------- driver: one full operation ----------------
    task automatic run_op(input int av, input int bv, input int exp_c, input int exp_lat,
                          input string tag);
        logic [N-1:0] c_before;
        int n;
        bit seen;
        @(negedge clk);
        a = av[N-1:0];
        b = bv[N-1:0];
        start = 1'b1;
        c_before = c;
        exp_q.push_back(exp_c[N-1:0]);
        @(posedge clk);              // acceptance edge
        @(negedge clk);
        start = 1'b0;
        a = N'($urandom);            // captured copy must be used from here on
        b = N'($urandom);
        check({tag, "_busy_after_accept"}, {31'd0, busy}, 32'd1);
        n = 0;
        seen = 1'b0;
        while (n < N + 4 && !seen) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (done) seen = 1'b1;
            else check({tag, "_hold_while_shifting"}, {27'd0, busy, c}, {27'd0, 1'b1, c_before});
        end
        check({tag, "_latency"}, seen ? n : -1, exp_lat);
        if (seen) begin
            check({tag, "_c"}, {28'd0, c}, {28'd0, exp_q.pop_front()});
            check({tag, "_busy_in_done"}, {31'd0, busy}, 32'd1);
            @(negedge clk);
            check({tag, "_idle_after"}, {30'd0, busy, done}, 32'd0);
        end else begin
            void'(exp_q.pop_front());
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int pulses;
        int cyc;
        int last_done;
        int ra;
        int rb;
        logic [N-1:0] c_last;

`ifdef SLL_SEQ_ROTATE_EN
        tbl[0] = '{1, 1, 2, 2};
        tbl[1] = '{3, 2, 12, 3};
        tbl[2] = '{2, 0, 2, 1};
        tbl[3] = '{9, 5, 3, 2};
        tbl[4] = '{9, 4, 9, 1};
        tbl[5] = '{5, 3, 10, 4};
        tbl[6] = '{15, 15, 15, 4};
        tbl[7] = '{9, 1, 3, 2};
`else
        tbl[0] = '{1, 1, 2, 2};
        tbl[1] = '{3, 2, 12, 3};
        tbl[2] = '{2, 0, 2, 1};
        tbl[3] = '{15, 5, 0, 5};
        tbl[4] = '{15, 4, 0, 5};
        tbl[5] = '{5, 3, 8, 4};
        tbl[6] = '{15, 15, 0, 5};
        tbl[7] = '{9, 1, 2, 2};
`endif

        // reset
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        #12;
        check("reset_state", {26'd0, c, busy, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // table-driven vectors
        for (int i = 0; i < 8; i++) begin
            run_op(tbl[i].a, tbl[i].b, tbl[i].exp_c, tbl[i].exp_lat, $sformatf("tbl%0d", i));
        end

        // randomized operations against the model
        for (int i = 0; i < 40; i++) begin
            ra = int'($urandom_range(0, MASK));
            rb = int'($urandom_range(0, MASK));
            run_op(ra, rb, model_c(ra, rb), model_steps(rb) + 1, $sformatf("rnd%0d", i));
        end

        // c held while idle
        c_last = c;
        repeat (3) @(negedge clk);
        check("c_hold_idle", {28'd0, c}, {28'd0, c_last});

        // start while busy is ignored
        @(negedge clk);
        a = 4'b0001; b = 4'd3; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 4'b0011; b = 4'd1; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        pulses = 0;
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                pulses++;
                check("busy_ignore_c", {28'd0, c}, 32'd8);
            end
        end
        check("busy_ignore_pulses", pulses, 1);

        // asynchronous reset mid-operation
        @(negedge clk);
        a = 4'b0001; b = 4'd3; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {26'd0, c, busy, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (8) begin
            @(posedge clk);
            @(negedge clk);
            if (done) pulses++;
        end
        check("no_done_after_reset", pulses, 0);
        run_op(2, 1, 4, 2, "post_reset");

        // start held high: back-to-back operations
        @(negedge clk);
        a = 4'b0001; b = 4'd1; start = 1'b1;
        pulses = 0;
        last_done = -1;
        cyc = 0;
        repeat (24) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (done) begin
                pulses++;
                check("held_start_c", {28'd0, c}, 32'd2);
                if (last_done >= 0) check("held_start_spacing", cyc - last_done, 4);
                last_done = cyc;
            end
        end
        start = 1'b0;
        check("held_start_pulses", (pulses >= 5) ? 1 : 0, 1);
        repeat (6) @(negedge clk);
        check("held_start_idle", {30'd0, busy, done}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sll_seq.md
Name: sll_seq

Overview:
Multi-cycle logical shift-left unit for the ALU lab: the left-shift counterpart of the combinational right shifter. It shifts operand a left by b positions, one bit per clock, under a start/busy/done handshake. It sits beside the ALU datapath and lets the same operand encoding (a = value, b = shift amount, c = result) be checked against a sequential implementation.

Parameters:
N, 4, operand/result width in bits (N >= 2).

Ports:
clk    input   1  rising-edge clock
rst_n  input   1  asynchronous reset, active-low
start  input   1  request; sampled only in IDLE
a      input   N  value to shift; captured when start is accepted
b      input   N  shift amount (unsigned); captured when start is accepted
c      output  N  result; updated only on completion and held until the next completion
busy   output  1  high in SHIFT and DONE
done   output  1  one-cycle pulse in DONE

Behaviour:
- Interface: single clock clk; reset rst_n is asynchronous and active-low.
- Reset (rst_n=0, any state, including mid-operation): state=IDLE, acc=0, cnt=0, c=0, busy=0, done=0. Any operation in flight is discarded, with no done pulse.
- Internal registers: acc[N-1:0], cnt (width clog2(N)+1), state in {IDLE, SHIFT, DONE}.
- IDLE: busy=0, done=0.
  - start=1 at edge k: acc<=a, cnt<=min(b,N), state<=SHIFT.
  - Shift amounts b >= N clamp to N, so the result is all zeros.
  - start=0: remain in IDLE.
- SHIFT: busy=1.
  - Each edge with cnt!=0: acc<=acc<<1 (zero fill at LSB), cnt<=cnt-1.
  - Edge with cnt==0: c<=acc, state<=DONE.
- DONE: busy=1, done=1 for exactly one cycle; the next edge goes to IDLE.
- Latency: with start accepted at edge k, done is high in the cycle after edge k+cnt+1.
  - b=0: done in the cycle after k+1.
  - Maximum (b >= N): cycle after k+N+1.
- start while busy=1 (SHIFT or DONE) is ignored and never queued. Back-to-back throughput is one operation per cnt+3 cycles, counting the IDLE cycle.
- a and b may change freely after acceptance; the result depends only on the captured values.
- c is unchanged from completion until the next DONE, or until reset.
- Arithmetic: result = (a << min(b,N)) truncated to N bits. Bits shifted out of the MSB are lost; no carry or overflow flag is produced.

Optional Feature:
SLL_SEQ_ROTATE_EN
- Defined:
  - The block performs rotate-left: each shift step does acc<={acc[N-2:0], acc[N-1]}.
  - Shift amount is loaded as cnt<=b mod N instead of clamping; b=N therefore yields c=a.
  - Latency rule is unchanged, using the loaded cnt.
- Undefined: logical shift-left with clamping, as above.
- Port list is identical in both builds.

Test Plan:
- N=4, a=0001, b=1, start pulsed at edge k -> busy high from k; done in the cycle after k+2; c=0010; busy low in the following cycle.
- a=0011, b=2 -> c=1100 with done after edge k+3. Then a=0010, b=0 -> c=0010 with done after edge k+1.
- a=1111, b=5 (clamped to 4) -> c=0000, done after edge k+5. Under SLL_SEQ_ROTATE_EN: a=1001, b=5 -> cnt=1, c=0011, done after edge k+2.
- Accept a=0001, b=3; pulse start with a=0011, b=1 while busy -> second request ignored; single done pulse; c=1000.
- Start a=0001, b=3; drive rst_n=0 after 2 shift cycles -> c=0, busy=0, done=0 immediately (asynchronous); no done pulse after release. A new request a=0010, b=1 -> c=0100.
- Hold start=1 continuously with a=0001, b=1 -> operations restart from IDLE; done pulses spaced 4 cycles apart; c=0010 each time.
